// File: rtl/riscv_pkg.sv
// Shared result-select encodings and MEM-stage FSM state type for the
// RISC-V pipeline slice.
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface mem_wb_stage_if;

    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for outstanding data-memory accesses; terminal is high
// once TIMEOUT-1 cycles have been counted since the last clear.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (incr) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign terminal = (count_q == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory handshake, pipeline stall, access timeout and
// the MEM/WB pipeline register.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  regwritem_i,
    input  logic [1:0]            resultsrcm_i,
    input  logic                  memwritem_i,
    input  logic [31:0]           aluresultm_i,
    input  logic [31:0]           writedatam_i,
    input  logic [4:0]            rdm_i,
    input  logic [31:0]           pcplus4m_i,
    mem_wb_stage_if.master        dmem,
    output logic                  stall_o,
    output logic                  regwritew_o,
    output logic [1:0]            resultsrcw_o,
    output logic [31:0]           aluresultw_o,
    output logic [31:0]           readdataw_o,
    output logic [4:0]            rdw_o,
    output logic [31:0]           pcplus4w_o,
    output logic                  err_o
);

    mem_state_t state_q, state_d;

    logic access;
    logic req;
    logic stall;
    logic tmr_clear;
    logic tmr_incr;
    logic tmr_terminal;
    logic abort;
    logic wb_bubble;
    logic load_done;

    assign access = memwritem_i | (resultsrcm_i == RESULT_MEM);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear    (tmr_clear),
        .incr     (tmr_incr),
        .terminal (tmr_terminal)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access && !dmem.dmem_ack_i) state_d = WAIT;
            WAIT: if (dmem.dmem_ack_i || tmr_terminal) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack has priority over the timeout in the terminal wait cycle.
    always_comb begin
        req       = 1'b0;
        stall     = 1'b0;
        tmr_clear = 1'b0;
        tmr_incr  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                req       = access;
                stall     = access & ~dmem.dmem_ack_i;
                tmr_clear = access & ~dmem.dmem_ack_i;
            end
            WAIT: begin
                req      = 1'b1;
                stall    = ~dmem.dmem_ack_i & ~tmr_terminal;
                tmr_incr = ~dmem.dmem_ack_i & ~tmr_terminal;
                abort    = ~dmem.dmem_ack_i & tmr_terminal;
            end
            default: ;
        endcase
        if (reset_i) begin
            req   = 1'b0;
            stall = 1'b0;
            abort = 1'b0;
        end
        wb_bubble = stall | abort;
        load_done = req & dmem.dmem_ack_i & (resultsrcm_i == RESULT_MEM);
    end

    assign dmem.dmem_req_o   = req;
    assign dmem.dmem_we_o    = req & memwritem_i;
    assign dmem.dmem_addr_o  = aluresultm_i;
    assign dmem.dmem_wdata_o = writedatam_i;
    assign stall_o           = stall;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            regwritew_o  <= 1'b0;
            resultsrcw_o <= RESULT_ALU;
            aluresultw_o <= '0;
            readdataw_o  <= '0;
            rdw_o        <= '0;
            pcplus4w_o   <= '0;
        end else if (wb_bubble) begin
            regwritew_o  <= 1'b0;
            resultsrcw_o <= RESULT_ALU;
            rdw_o        <= '0;
        end else begin
            regwritew_o  <= regwritem_i;
            resultsrcw_o <= resultsrcm_i;
            aluresultw_o <= aluresultm_i;
            rdw_o        <= rdm_i;
            pcplus4w_o   <= pcplus4m_i;
            if (load_done) begin
                readdataw_o <= dmem.dmem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_o <= 1'b0;
        end else if (abort) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// instructions with random memory latency against a transaction-level model.
module tb_mem_wb_stage;
    import riscv_pkg::*;

    localparam int unsigned TIMEOUT = 4;

    typedef struct {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        regwritem_i;
    logic [1:0]  resultsrcm_i;
    logic        memwritem_i;
    logic [31:0] aluresultm_i;
    logic [31:0] writedatam_i;
    logic [4:0]  rdm_i;
    logic [31:0] pcplus4m_i;
    logic        stall_o;
    logic        regwritew_o;
    logic [1:0]  resultsrcw_o;
    logic [31:0] aluresultw_o;
    logic [31:0] readdataw_o;
    logic [4:0]  rdw_o;
    logic [31:0] pcplus4w_o;
    logic        err_o;

    mem_wb_stage_if dmem ();

    mem_wb_stage #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .regwritem_i  (regwritem_i),
        .resultsrcm_i (resultsrcm_i),
        .memwritem_i  (memwritem_i),
        .aluresultm_i (aluresultm_i),
        .writedatam_i (writedatam_i),
        .rdm_i        (rdm_i),
        .pcplus4m_i   (pcplus4m_i),
        .dmem         (dmem),
        .stall_o      (stall_o),
        .regwritew_o  (regwritew_o),
        .resultsrcw_o (resultsrcw_o),
        .aluresultw_o (aluresultw_o),
        .readdataw_o  (readdataw_o),
        .rdw_o        (rdw_o),
        .pcplus4w_o   (pcplus4w_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Expected MEM/WB register contents and sticky error.
    logic        exp_regwrite;
    logic [1:0]  exp_resultsrc;
    logic [31:0] exp_alu;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_rd;
    logic [31:0] exp_pc4;
    logic        exp_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_regwrite  = 1'b0;
        exp_resultsrc = RESULT_ALU;
        exp_alu       = '0;
        exp_rdata     = '0;
        exp_rd        = '0;
        exp_pc4       = '0;
        exp_err       = 1'b0;
    endtask

    task automatic model_bubble();
        exp_regwrite  = 1'b0;
        exp_resultsrc = RESULT_ALU;
        exp_rd        = '0;
    endtask

    task automatic check_w(input string ctx);
        check_eq({ctx, ".regwritew"},  32'(regwritew_o),  32'(exp_regwrite));
        check_eq({ctx, ".resultsrcw"}, 32'(resultsrcw_o), 32'(exp_resultsrc));
        check_eq({ctx, ".aluresultw"}, aluresultw_o,      exp_alu);
        check_eq({ctx, ".readdataw"},  readdataw_o,       exp_rdata);
        check_eq({ctx, ".rdw"},        32'(rdw_o),        32'(exp_rd));
        check_eq({ctx, ".pcplus4w"},   pcplus4w_o,        exp_pc4);
        check_eq({ctx, ".err"},        32'(err_o),        32'(exp_err));
    endtask

    function automatic instr_t make_instr(input int kind);
        instr_t ins;
        ins.regwrite = 1'($urandom_range(0, 1));
        ins.alu      = $urandom;
        ins.wdata    = $urandom;
        ins.rd       = 5'($urandom_range(0, 31));
        ins.pc4      = $urandom;
        ins.memwrite = 1'b0;
        case (kind)
            1: ins.resultsrc = RESULT_MEM;
            2: begin
                ins.memwrite  = 1'b1;
                ins.regwrite  = 1'b0;
                ins.resultsrc = ($urandom_range(0, 1) == 0) ? RESULT_ALU : RESULT_PC4;
            end
            default: ins.resultsrc = ($urandom_range(0, 1) == 0) ? RESULT_ALU : RESULT_PC4;
        endcase
        return ins;
    endfunction

    // Entered and left at a falling edge. ack_at is the cycle (0 = first)
    // in which memory acknowledges; negative means never. spur drives ack
    // for non-memory instructions.
    task automatic run_instr(input string ctx, input instr_t ins, input int ack_at, input logic spur);
        logic access;
        logic done;
        access       = ins.memwrite || (ins.resultsrc == RESULT_MEM);
        regwritem_i  = ins.regwrite;
        resultsrcm_i = ins.resultsrc;
        memwritem_i  = ins.memwrite;
        aluresultm_i = ins.alu;
        writedatam_i = ins.wdata;
        rdm_i        = ins.rd;
        pcplus4m_i   = ins.pc4;
        done         = 1'b0;
        for (int c = 0; c <= int'(TIMEOUT) && !done; c++) begin
            logic        ack_now;
            logic        exp_stall;
            logic [31:0] rdata;
            ack_now = access ? (c == ack_at) : spur;
            rdata   = $urandom;
            dmem.dmem_ack_i   = ack_now;
            dmem.dmem_rdata_i = rdata;
            #1;
            check_eq({ctx, ".req"}, 32'(dmem.dmem_req_o), 32'(access));
            if (access) begin
                check_eq({ctx, ".we"},    32'(dmem.dmem_we_o), 32'(ins.memwrite));
                check_eq({ctx, ".addr"},  dmem.dmem_addr_o,    ins.alu);
                check_eq({ctx, ".wdata"}, dmem.dmem_wdata_o,   ins.wdata);
            end
            if (!access || ack_now) begin
                exp_stall     = 1'b0;
                exp_regwrite  = ins.regwrite;
                exp_resultsrc = ins.resultsrc;
                exp_alu       = ins.alu;
                exp_rd        = ins.rd;
                exp_pc4       = ins.pc4;
                if (access && ins.resultsrc == RESULT_MEM) exp_rdata = rdata;
                done = 1'b1;
            end else if (c == int'(TIMEOUT)) begin
                exp_stall = 1'b0;
                model_bubble();
                exp_err = 1'b1;
                done    = 1'b1;
            end else begin
                exp_stall = 1'b1;
                model_bubble();
            end
            check_eq({ctx, ".stall"}, 32'(stall_o), 32'(exp_stall));
            @(posedge clk_i);
            #1;
            check_w(ctx);
            @(negedge clk_i);
        end
        dmem.dmem_ack_i = 1'b0;
    endtask

    initial begin
        instr_t ins;
        int     ack_at;
        int     r;

        reset_i           = 1'b1;
        regwritem_i       = 1'b1;
        resultsrcm_i      = RESULT_MEM;
        memwritem_i       = 1'b1;
        aluresultm_i      = 32'h1234_5678;
        writedatam_i      = 32'hCAFE_F00D;
        rdm_i             = 5'd7;
        pcplus4m_i        = 32'h4;
        dmem.dmem_ack_i   = 1'b0;
        dmem.dmem_rdata_i = '0;
        model_reset();

        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst.req",   32'(dmem.dmem_req_o), 32'd0);
        check_eq("rst.we",    32'(dmem.dmem_we_o),  32'd0);
        check_eq("rst.stall", 32'(stall_o),         32'd0);
        check_w("rst");
        @(negedge clk_i);
        reset_i = 1'b0;

        // ALU op, then zero-wait load, then store with 3-cycle ack delay.
        ins = make_instr(0);
        ins.regwrite = 1'b1; ins.resultsrc = RESULT_ALU; ins.rd = 5'd5; ins.alu = 32'h10;
        run_instr("alu", ins, -1, 1'b0);
        ins = make_instr(1);
        ins.alu = 32'h100;
        run_instr("ld0", ins, 0, 1'b0);
        ins = make_instr(2);
        run_instr("st3", ins, 3, 1'b0);

        // No ack: timeout abort, then a normal ALU op and a PC+4 op.
        ins = make_instr(2);
        run_instr("tmo", ins, -1, 1'b0);
        ins = make_instr(0);
        ins.regwrite = 1'b1; ins.resultsrc = RESULT_ALU;
        run_instr("post_tmo", ins, -1, 1'b0);

        // Spurious ack on a pass-through instruction.
        ins = make_instr(0);
        ins.resultsrc = RESULT_PC4;
        run_instr("spur", ins, -1, 1'b1);

        // Asynchronous reset in the middle of a WAIT.
        ins = make_instr(1);
        regwritem_i       = ins.regwrite;
        resultsrcm_i      = ins.resultsrc;
        memwritem_i       = ins.memwrite;
        aluresultm_i      = ins.alu;
        writedatam_i      = ins.wdata;
        rdm_i             = ins.rd;
        pcplus4m_i        = ins.pc4;
        dmem.dmem_ack_i   = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check_eq("arst.pre_stall", 32'(stall_o), 32'd1);
        check_eq("arst.pre_err",   32'(err_o),   32'd1);
        #1;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_eq("arst.req",   32'(dmem.dmem_req_o), 32'd0);
        check_eq("arst.stall", 32'(stall_o),         32'd0);
        check_w("arst");
        @(negedge clk_i);
        memwritem_i  = 1'b0;
        resultsrcm_i = RESULT_ALU;
        reset_i      = 1'b0;

        // First instruction after reset release: zero-wait load.
        ins = make_instr(1);
        run_instr("after_rst", ins, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ins = make_instr(int'($urandom_range(0, 2)));
            r   = int'($urandom_range(0, 9));
            if (r < 6)      ack_at = int'($urandom_range(0, 2));
            else if (r < 8) ack_at = int'($urandom_range(3, TIMEOUT + 1));
            else            ack_at = -1;
            run_instr("rand", ins, ack_at, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
